dmux_1by4_deser: RTL

Four-channel serial-to-parallel collector that sits directly downstream of the 1-to-4 demultiplexer (DMUX_1by4_bf). Each strobed bit steered to channel k by the demux is shifted into that channel's WIDTH-bit word. When a word completes, the channel presents it on its parallel output with a one-cycle valid pulse. Channels are independent, so four interleaved serial streams can share one demux.

---
 rtl/dmux_pkg.sv | 19 +
 rtl/dmux_deser_ch.sv | 67 ++++++
 rtl/dmux_1by4_deser.sv | 45 ++++
 3 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-4 demux deserializer.
package dmux_pkg;

  localparam int unsigned NCH = 4;

  // Channel select driving both the demux and the deserializer.
  typedef logic [1:0] ch_sel_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_deser_ch.sv
// Single-channel LSB-first serial-to-parallel shifter with output register.
module dmux_deser_ch
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             b,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy
);

  localparam int unsigned    CntW    = clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  // Next-state: clear wins over a strobe; the last bit completes the word.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CntLast) begin
        word_d  = {b, sh_q[WIDTH-2:0]};
        valid_d = 1'b1;
        sh_d    = '0;
        cnt_d   = '0;
      end else begin
        // Bits above cnt_q are still zero, so OR-ing places b at position cnt_q.
        sh_d  = sh_q | ({{(WIDTH-1){1'b0}}, b} << cnt_q);
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign q       = word_q;
  assign q_valid = valid_q;
  assign busy    = (cnt_q != '0);

endmodule

// File: rtl/dmux_1by4_deser.sv
// Four independent deserializer channels fed from the 1-to-4 demux outputs.
module dmux_1by4_deser
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe,
  input  ch_sel_t              s,
  input  logic [NCH-1:0]       y,
  input  logic                 clear,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       q_valid,
  output logic [NCH-1:0]       busy
);

  logic           b;
  logic [NCH-1:0] en;

  // Only the selected channel advances, and never in a clear cycle.
  always_comb begin
    b  = y[s];
    en = '0;
    for (int k = 0; k < NCH; k++) begin
      en[k] = strobe & (s == ch_sel_t'(k)) & ~clear;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    dmux_deser_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .en     (en[k]),
      .b      (b),
      .q      (q[k*WIDTH +: WIDTH]),
      .q_valid(q_valid[k]),
      .busy   (busy[k])
    );
  end

endmodule
